mlaccel_memory: RTL and testbench



---
 rtl/mlaccel_mem_pkg.sv | 31 +++
 rtl/mlaccel_memory_bank.sv | 37 +++
 rtl/mlaccel_memory.sv | 101 ++++++++++
 tb/tb_mlaccel_memory.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_mem_pkg.sv
// Shared types and constants for the accelerator data memory.
// Request bundle carried from the arbiter into the array stage.
package mlaccel_mem_pkg;

    localparam int WORD_BITS    = 64;
    localparam int STRB_BITS    = 8;
    localparam int ADDR_BITS    = 16;
    localparam int READ_LATENCY = 2;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_COMPUTE,
        PORT_HOST
    } port_e;

    typedef struct packed {
        port_e                  port;
        logic                   rd;
        logic [STRB_BITS-1:0]   strb;
        logic [ADDR_BITS-1:0]   index;
        logic [WORD_BITS-1:0]   wdata;
    } req_t;

    function automatic logic [ADDR_BITS-1:0] wrap_index(
        input logic [ADDR_BITS-1:0] addr,
        input int unsigned          words
    );
        return ADDR_BITS'({16'b0, addr} % words);
    endfunction

endpackage

// File: rtl/mlaccel_memory_bank.sv
// Byte-enabled synchronous RAM, read-first, registered output.
// Written to map onto a single block RAM primitive.
module mlaccel_memory_bank
    import mlaccel_mem_pkg::*;
#(
    parameter int WORDS = 16384
) (
    input  logic                 clock,
    input  logic                 en_i,
    input  logic [STRB_BITS-1:0] we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [WORD_BITS-1:0] mem_q [WORDS];
    logic [WORD_BITS-1:0] rdata_q;
    logic [IDX_W-1:0]     idx;

    assign idx     = IDX_W'({16'b0, addr_i} % WORDS);
    assign rdata_o = rdata_q;

    // Non-blocking read and write of the same word give read-first data.
    always_ff @(posedge clock) begin
        if (en_i) begin
            rdata_q <= mem_q[idx];
            for (int k = 0; k < STRB_BITS; k++) begin
                if (we_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mlaccel_memory.sv
// Shared data memory: fixed-latency compute port, host port using idle slots.
// Arbiter and request register feed the bank; output stage steers read data.
module mlaccel_memory
    import mlaccel_mem_pkg::*;
#(
    parameter int WORDS = 16384
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_ren,
    input  logic [STRB_BITS-1:0] mem_wen,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [WORD_BITS-1:0] mem_wdata,
    output logic [WORD_BITS-1:0] mem_rdata,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic                 host_write,
    input  logic [STRB_BITS-1:0] host_wstrb,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [WORD_BITS-1:0] host_wdata,
    output logic                 host_rvalid,
    output logic [WORD_BITS-1:0] host_rdata,
    output logic                 err
);

    logic                 cmp_act;
    req_t                 s1_d, s1_q;
    logic                 cmp_rd_d, cmp_rd_q;
    logic                 host_rd_d, host_rd_q;
    logic                 err_d, err_q;
    logic [WORD_BITS-1:0] mem_hold_d, mem_hold_q;
    logic [WORD_BITS-1:0] host_hold_d, host_hold_q;
    logic [WORD_BITS-1:0] bank_rdata;
    logic                 bank_en;

    assign cmp_act    = mem_ren || (|mem_wen);
    assign host_ready = reset && !cmp_act;

    always_comb begin
        s1_d      = '0;
        s1_d.port = PORT_NONE;
        if (cmp_act) begin
            s1_d.port  = PORT_COMPUTE;
            s1_d.rd    = mem_ren;
            s1_d.strb  = mem_wen;
            s1_d.index = wrap_index(mem_addr, WORDS);
            s1_d.wdata = mem_wdata;
        end else if (host_valid) begin
            s1_d.port  = PORT_HOST;
            s1_d.rd    = !host_write;
            s1_d.strb  = host_write ? host_wstrb : '0;
            s1_d.index = wrap_index(host_addr, WORDS);
            s1_d.wdata = host_wdata;
        end
    end

    // Gating with reset drops a write that reaches the array on a reset edge.
    assign bank_en = reset && (s1_q.port != PORT_NONE);

    mlaccel_memory_bank #(
        .WORDS(WORDS)
    ) u_bank (
        .clock  (clock),
        .en_i   (bank_en),
        .we_i   (s1_q.strb),
        .addr_i (s1_q.index),
        .wdata_i(s1_q.wdata),
        .rdata_o(bank_rdata)
    );

    always_comb begin
        cmp_rd_d    = (s1_q.port == PORT_COMPUTE) && s1_q.rd;
        host_rd_d   = (s1_q.port == PORT_HOST) && s1_q.rd;
        err_d       = err_q || (mem_ren && (|mem_wen));
        mem_rdata   = cmp_rd_q ? bank_rdata : mem_hold_q;
        host_rdata  = host_rd_q ? bank_rdata : host_hold_q;
        host_rvalid = host_rd_q;
        err         = err_q;
        mem_hold_d  = mem_rdata;
        host_hold_d = host_rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q        <= '0;
            cmp_rd_q    <= 1'b0;
            host_rd_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            s1_q        <= s1_d;
            cmp_rd_q    <= cmp_rd_d;
            host_rd_q   <= host_rd_d;
            err_q       <= err_d;
            mem_hold_q  <= mem_hold_d;
            host_hold_q <= host_hold_d;
        end
    end

endmodule

// File: tb/tb_mlaccel_memory.sv
// Randomized scoreboard bench for mlaccel_memory against a word-array model.
// Directed scenarios first, then mixed random traffic with occasional resets.
module tb_mlaccel_memory;

    localparam int WORDS = 16384;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        mem_ren;
    logic [7:0]  mem_wen;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        host_valid;
    logic        host_ready;
    logic        host_write;
    logic [7:0]  host_wstrb;
    logic [15:0] host_addr;
    logic [63:0] host_wdata;
    logic        host_rvalid;
    logic [63:0] host_rdata;
    logic        err;

    mlaccel_memory #(.WORDS(WORDS)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_write (host_write),
        .host_wstrb (host_wstrb),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    logic [63:0] ref_mem [WORDS];
    exp_t        cq[$];
    exp_t        hq[$];
    logic [63:0] exp_m = '0;
    logic [63:0] exp_h = '0;
    logic        exp_err = 1'b0;
    bit          lw_v = 0;
    int          lw_i = 0;
    logic [63:0] lw_old = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] be);
        for (int k = 0; k < 8; k++)
            if (be[k]) old[8*k +: 8] = nw[8*k +: 8];
        return old;
    endfunction

    task automatic model_write(input int idx, input logic [63:0] d,
                               input logic [7:0] be);
        lw_v   = 1;
        lw_i   = idx;
        lw_old = ref_mem[idx];
        ref_mem[idx] = merge(ref_mem[idx], d, be);
    endtask

    // Drive one cycle of requests, update the model, advance to next negedge.
    task automatic step(input logic rn, input logic [7:0] wn,
                        input logic [15:0] a, input logic [63:0] wd,
                        input logic hv, input logic hw, input logic [7:0] hs,
                        input logic [15:0] ha, input logic [63:0] hd,
                        input logic rs);
        int   idx;
        exp_t e;
        #1;
        mem_ren = rn; mem_wen = wn; mem_addr = a; mem_wdata = wd;
        host_valid = hv; host_write = hw; host_wstrb = hs;
        host_addr = ha; host_wdata = hd; reset = rs;
        #1;
        if (mon_en)
            chk("host_ready", {63'b0, host_ready},
                {63'b0, rs && !rn && (wn == 8'h00)});
        if (!rs) begin
            if (lw_v) ref_mem[lw_i] = lw_old;
            lw_v = 0;
            cq.delete();
            hq.delete();
            exp_m = '0;
            exp_h = '0;
            exp_err = 1'b0;
        end else begin
            lw_v = 0;
            if (rn || (wn != 0)) begin
                idx = int'(a) % WORDS;
                if (rn) begin
                    e.due = cyc + 2; e.data = ref_mem[idx];
                    cq.push_back(e);
                end
                if (rn && (wn != 0)) exp_err = 1'b1;
                if (wn != 0) model_write(idx, wd, wn);
            end else if (hv) begin
                idx = int'(ha) % WORDS;
                if (!hw) begin
                    e.due = cyc + 2; e.data = ref_mem[idx];
                    hq.push_back(e);
                end else if (hs != 0) begin
                    model_write(idx, hd, hs);
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 8'h00, 16'h0, 64'h0, 0, 0, 8'h00, 16'h0, 64'h0, 1);
    endtask

    task automatic cwr(input logic [15:0] a, input logic [63:0] d,
                       input logic [7:0] be);
        step(0, be, a, d, 0, 0, 8'h00, 16'h0, 64'h0, 1);
    endtask

    task automatic crd(input logic [15:0] a);
        step(1, 8'h00, a, 64'h0, 0, 0, 8'h00, 16'h0, 64'h0, 1);
    endtask

    bit hexp;
    always @(negedge clock) begin
        if (mon_en) begin
            if (cq.size() != 0 && cq[0].due == cyc) begin
                exp_m = cq[0].data;
                void'(cq.pop_front());
            end
            chk("mem_rdata", mem_rdata, exp_m);
            hexp = (hq.size() != 0 && hq[0].due == cyc);
            chk("host_rvalid", {63'b0, host_rvalid}, {63'b0, hexp});
            if (hexp) begin
                exp_h = hq[0].data;
                void'(hq.pop_front());
            end
            chk("host_rdata", host_rdata, exp_h);
            chk("err", {63'b0, err}, {63'b0, exp_err});
        end
    end

    logic        r_rn, r_hv, r_hw;
    logic [7:0]  r_wn, r_hs;
    logic [15:0] r_a, r_ha;

    initial begin
        reset = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_wdata = 0;
        host_valid = 0; host_write = 0; host_wstrb = 0;
        host_addr = 0; host_wdata = 0;
        @(negedge clock);
        step(0, 8'h00, 16'h0, 64'h0, 0, 0, 8'h00, 16'h0, 64'h0, 0);
        step(0, 8'h00, 16'h0, 64'h0, 0, 0, 8'h00, 16'h0, 64'h0, 0);
        mon_en = 1;
        chk("reset_mem_rdata", mem_rdata, 64'h0);
        chk("reset_host_ready", {63'b0, host_ready}, 64'h0);

        for (int i = 0; i < 32; i++)
            cwr(16'(i), {$urandom, $urandom}, 8'hFF);

        cwr(16'h0010, 64'h0123456789ABCDEF, 8'hFF);
        crd(16'h0010);
        idle();
        chk("basic_rd", mem_rdata, 64'h0123456789ABCDEF);

        cwr(16'h0005, 64'h1111111111111111, 8'hFF);
        cwr(16'h0005, 64'hAA000000000000BB, 8'h81);
        crd(16'h0005);
        idle();
        chk("byte_en", mem_rdata, 64'hAA111111111111BB);

        cwr(16'h0020, 64'h00000000C0FFEE00, 8'hFF);
        for (int i = 0; i < 4; i++)
            step(1, 8'h00, 16'h0011, 64'h0, 1, 0, 8'h00, 16'h0020, 64'h0, 1);
        step(0, 8'h00, 16'h0, 64'h0, 1, 0, 8'h00, 16'h0020, 64'h0, 1);
        chk("prio_no_rvalid_yet", {63'b0, host_rvalid}, 64'h0);
        idle();
        chk("prio_rvalid", {63'b0, host_rvalid}, 64'h1);
        chk("prio_rdata", host_rdata, 64'h00000000C0FFEE00);
        idle();
        chk("prio_pulse_end", {63'b0, host_rvalid}, 64'h0);

        cwr(16'h0007, 64'h5, 8'hFF);
        step(1, 8'hFF, 16'h0007, 64'h9, 0, 0, 8'h00, 16'h0, 64'h0, 1);
        idle();
        chk("collide_old", mem_rdata, 64'h5);
        chk("collide_err", {63'b0, err}, 64'h1);
        crd(16'h0007);
        idle();
        chk("collide_new", mem_rdata, 64'h9);

        cwr(16'h4003, 64'hDEAD, 8'hFF);
        crd(16'h0003);
        idle();
        chk("wrap", mem_rdata, 64'hDEAD);

        step(0, 8'h00, 16'h0, 64'h0, 1, 1, 8'h00, 16'h0004, 64'h77, 1);
        step(0, 8'h00, 16'h0, 64'h0, 1, 0, 8'h00, 16'h0020, 64'h0, 1);
        step(0, 8'h00, 16'h0, 64'h0, 0, 0, 8'h00, 16'h0, 64'h0, 0);
        chk("rst_mem_rdata", mem_rdata, 64'h0);
        chk("rst_host_rdata", host_rdata, 64'h0);
        chk("rst_rvalid", {63'b0, host_rvalid}, 64'h0);
        chk("rst_err", {63'b0, err}, 64'h0);
        chk("rst_host_ready", {63'b0, host_ready}, 64'h0);
        for (int i = 0; i < 4; i++) idle();

        for (int i = 0; i < 1500; i++) begin
            r_rn = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                3:       r_wn = 8'hFF;
                4:       r_wn = 8'($urandom);
                default: r_wn = 8'h00;
            endcase
            if (r_rn && r_wn != 0 && $urandom_range(0, 3) != 0) r_wn = 8'h00;
            r_a  = 16'($urandom_range(0, 31) + 16384 * $urandom_range(0, 3));
            r_ha = 16'($urandom_range(0, 31) + 16384 * $urandom_range(0, 3));
            r_hv = ($urandom_range(0, 1) == 1);
            r_hw = ($urandom_range(0, 1) == 1);
            r_hs = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            step(r_rn, r_wn, r_a, {$urandom, $urandom}, r_hv, r_hw, r_hs,
                 r_ha, {$urandom, $urandom},
                 ($urandom_range(0, 99) != 0));
        end
        for (int i = 0; i < 4; i++) idle();
        chk("drain", 64'(cq.size() + hq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
